// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   mdu_op_e    : 4-bit operation encoding carried on mdu_op
//   mdu_state_e : sequencer states (IDLE / RUN)
//   is_mul_class / is_div_class : classify ops that occupy the unit for
//                 MUL_CYCLES / DIV_CYCLES busy cycles.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops 9..12).
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Accumulate ops only count as multiply-class when the adder is built;
  // otherwise they fall through as no-ops.
  function automatic logic is_mul_class(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// -----------------------------------------------------------------------------
// mdu_calc -- combinational datapath of the multiply/divide unit.
// Produces the {HI,LO} pair an operation will eventually commit.
//   op             : operation code (mdu_pkg::mdu_op_e encoding)
//   d1, d2         : rs / rt operands
//   acc_hi, acc_lo : current HI/LO, the addend of MADD*/MSUB*
//   res_hi, res_lo : result pair
// Optional feature macro: MDU_MADD_EN (builds the accumulate adder).
// -----------------------------------------------------------------------------
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Explicit extension to 2*WIDTH makes the truncated product exact for both
  // signednesses.
  logic [W2-1:0] prod_s;
  logic [W2-1:0] prod_u;
  assign prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
  assign prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};

  logic div_zero;
  logic div_ovf;
  assign div_zero = (d2 == '0);
  assign div_ovf  = (d1 == MOST_NEG) && (d2 == '1);

  logic [WIDTH-1:0] quo_s, rem_s, quo_u, rem_u;

  // SV signed / and % already truncate toward zero with the remainder taking
  // the dividend's sign; only the zero and overflow corners need overriding.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    quo_s = '1;
    rem_s = d1;
    quo_u = '1;
    rem_u = d1;
    if (!div_zero) begin
      if (div_ovf) begin
        quo_s = MOST_NEG;
        rem_s = '0;
      end else begin
        quo_s = $signed(d1) / $signed(d2);
        rem_s = $signed(d1) % $signed(d2);
      end
      quo_u = d1 / d2;
      rem_u = d1 % d2;
    end
  end

`ifdef MDU_MADD_EN
  logic [W2-1:0] acc;
  logic [W2-1:0] acc_res;
  assign acc = {acc_hi, acc_lo};

  always_comb begin
    acc_res = acc;
    case (op)
      OP_MADD:  acc_res = acc + prod_s;
      OP_MADDU: acc_res = acc + prod_u;
      OP_MSUB:  acc_res = acc - prod_s;
      OP_MSUBU: acc_res = acc - prod_u;
      default:  acc_res = acc;
    endcase
  end
`else
  logic unused_acc;
  assign unused_acc = ^{acc_hi, acc_lo};
`endif

  always_comb begin
    {res_hi, res_lo} = '0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = {rem_s, quo_s};
      OP_DIVU:  {res_hi, res_lo} = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {res_hi, res_lo} = acc_res;
`endif
      default:  {res_hi, res_lo} = '0;
    endcase
  end

endmodule

// File: rtl/mdu_gen.sv
// -----------------------------------------------------------------------------
// mdu_gen -- multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed on the accepting edge, held in a pending register
// for MUL_CYCLES / DIV_CYCLES busy cycles, then committed to HI/LO on the
// edge that drops busy.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   start   : operation request, qualified by mdu_op
//   mdu_op  : operation code (mdu_pkg::mdu_op_e)
//   d1, d2  : rs / rt operands
//   req     : exception/interrupt flush, blocks new ops only
//   busy    : operation in flight
//   out     : MFHI/MFLO read data (combinational)
//   hi, lo  : architectural HI/LO
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
// -----------------------------------------------------------------------------
module mdu_gen
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

  mdu_state_e       state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (mdu_op),
    .d1     (d1),
    .d2     (d2),
    .acc_hi (hi),
    .acc_lo (lo),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  // cnt holds the busy cycles still to run; the edge that sees 1 commits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !req) begin
            if (is_mul_class(mdu_op) || is_div_class(mdu_op)) begin
              state   <= S_RUN;
              busy    <= 1'b1;
              cnt     <= is_div_class(mdu_op) ? DIV_N : MUL_N;
              pend_hi <= calc_hi;
              pend_lo <= calc_lo;
            end else if (mdu_op == OP_MTHI) begin
              hi <= d1;
            end else if (mdu_op == OP_MTLO) begin
              lo <= d1;
            end
          end
        end
        S_RUN: begin
          // start and req are deliberately not looked at here.
          if (cnt == 6'd1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= pend_hi;
            lo    <= pend_lo;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    case (mdu_op)
      OP_MFHI: out = hi;
      OP_MFLO: out = lo;
      default: out = '0;
    endcase
  end

endmodule
